// File: rtl/enc_pkg.sv
// Shared definitions for the 256-to-8 encoder stage and its event FIFO.
// Holds default sizes, occupancy state encodings and the count-width helper.
package enc_pkg;

    localparam int ENC_WIDTH  = 8;
    localparam int FIFO_DEPTH = 16;

    // Occupancy states of the event FIFO; kept as plain constants for legacy tools.
    localparam logic [1:0] OCC_EMPTY   = 2'd0;
    localparam logic [1:0] OCC_PARTIAL = 2'd1;
    localparam logic [1:0] OCC_FULL    = 2'd2;

    // A count must represent 0..depth inclusive, hence one bit above the pointer width.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/enc_edge_detect.sv
// Turns the encoder's level-valid output into single-cycle events: a new event
// whenever valid rises or the index changes while valid stays high.
module enc_edge_detect
    import enc_pkg::*;
#(
    parameter int WIDTH = ENC_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] enc_in,
    input  logic             enc_valid,
    output logic             ev
);

    logic             prev_valid;
    logic [WIDTH-1:0] prev_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_valid <= 1'b0;
            prev_idx   <= '0;
        end else begin
            prev_valid <= enc_valid;
            prev_idx   <= enc_in;
        end
    end

    assign ev = enc_valid & (~prev_valid | (enc_in != prev_idx));

endmodule

// File: rtl/enc_event_fifo.sv
// Event FIFO behind the 256-to-8 encoder: stores each distinct encoder event
// and presents the oldest on a valid/ready read port; drops and flags on full.
module enc_event_fifo
    import enc_pkg::*;
#(
    parameter int WIDTH = ENC_WIDTH,
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              enc_in,
    input  logic                          enc_valid,
    output logic [WIDTH-1:0]              rd_data,
    output logic                          rd_valid,
    input  logic                          rd_ready,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          full,
    output logic                          overflow,
    input  logic                          clr_ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);

    // Read handshake: an entry transfers on a rising clk edge where rd_valid and
    // rd_ready are both high; rd_valid never depends on rd_ready, and rd_data
    // holds steady while rd_valid is high and rd_ready is low.

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [1:0]       occ_state;
    logic             ev;
    logic             push;
    logic             pop;

    enc_edge_detect #(
        .WIDTH (WIDTH)
    ) u_edge (
        .clk       (clk),
        .rst_n     (rst_n),
        .enc_in    (enc_in),
        .enc_valid (enc_valid),
        .ev        (ev)
    );

    always_comb begin
        occ_state = OCC_PARTIAL;
        if (count == '0)
            occ_state = OCC_EMPTY;
        else if (count == CW'(DEPTH))
            occ_state = OCC_FULL;
    end

    assign rd_valid = (occ_state != OCC_EMPTY);
    assign full     = (occ_state == OCC_FULL);
    assign pop      = rd_valid & rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push     = ev & (~full | pop);
    assign rd_data  = mem[rd_ptr];

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= enc_in;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            if (push && !pop)
                count <= count + CW'(1);
            else if (pop && !push)
                count <= count - CW'(1);
        end
    end

    // Setting has priority over the clear so a drop is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (ev && full && !pop)
            overflow <= 1'b1;
        else if (clr_ovf)
            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_enc_event_fifo.sv
// Directed bench for enc_event_fifo: event collapse, ordering, full/overflow,
// full push+pop, pointer wrap and mid-stream reset.
module tb_enc_event_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] enc_in;
    logic             enc_valid;
    logic [WIDTH-1:0] rd_data;
    logic             rd_valid;
    logic             rd_ready;
    logic [4:0]       count;
    logic             full;
    logic             overflow;
    logic             clr_ovf;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [WIDTH-1:0] exp_q[$];

    enc_event_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enc_in    (enc_in),
        .enc_valid (enc_valid),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .count     (count),
        .full      (full),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge, then settle 1 time unit past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    initial begin
        rst_n     = 1'b0;
        enc_in    = '0;
        enc_valid = 1'b0;
        rd_ready  = 1'b0;
        clr_ovf   = 1'b0;
        step();
        step();
        check("reset_count", 32'(count), 0);
        check("reset_rd_valid", 32'(rd_valid), 0);
        check("reset_full", 32'(full), 0);
        check("reset_overflow", 32'(overflow), 0);
        rst_n = 1'b1;
        step();

        // event collapse: held index gives one entry
        enc_valid = 1'b1;
        enc_in    = 8'h2A;
        step();
        check("collapse_latency_valid", 32'(rd_valid), 1);
        check("collapse_latency_data", 32'(rd_data), 32'h2A);
        for (int i = 0; i < 4; i++) step();
        check("collapse_count", 32'(count), 1);
        check("collapse_data", 32'(rd_data), 32'h2A);
        enc_valid = 1'b0;
        rd_ready  = 1'b1;
        step();
        check("collapse_pop_count", 32'(count), 0);
        step();
        check("empty_ready_count", 32'(count), 0);
        check("empty_ready_valid", 32'(rd_valid), 0);
        rd_ready = 1'b0;

        // index change with valid held
        enc_valid = 1'b1;
        enc_in    = 8'h05;
        step();
        enc_in = 8'hFF;
        step();
        enc_valid = 1'b0;
        check("change_count", 32'(count), 2);
        step();
        check("change_stall_data", 32'(rd_data), 32'h05);
        rd_ready = 1'b1;
        step();
        check("change_pop2_data", 32'(rd_data), 32'hFF);
        check("change_pop1_count", 32'(count), 1);
        step();
        check("change_drain_count", 32'(count), 0);
        rd_ready = 1'b0;

        // fill with 17 distinct events, last one dropped
        enc_valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            enc_in = 8'(8'h10 + i);
            step();
        end
        enc_valid = 1'b0;
        check("fill_full", 32'(full), 1);
        check("fill_count", 32'(count), 16);
        check("fill_overflow", 32'(overflow), 1);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("fill_pop_%0d", i), 32'(rd_data), 32'(8'h10 + i));
            step();
        end
        rd_ready = 1'b0;
        check("fill_drained", 32'(count), 0);
        check("ovf_sticky", 32'(overflow), 1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);

        // full with simultaneous push and pop
        enc_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            enc_in = 8'(8'h40 + i);
            step();
        end
        check("fpp_pre_count", 32'(count), 16);
        enc_in   = 8'h99;
        rd_ready = 1'b1;
        step();
        enc_valid = 1'b0;
        check("fpp_count", 32'(count), 16);
        check("fpp_overflow", 32'(overflow), 0);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("fpp_pop_%0d", i), 32'(rd_data), (i == 15) ? 32'h99 : 32'(8'h41 + i));
            step();
        end
        rd_ready = 1'b0;
        check("fpp_drained", 32'(count), 0);

        // drop coinciding with clr_ovf: set wins
        enc_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            enc_in = 8'(8'h60 + i);
            step();
        end
        enc_in  = 8'h70;
        clr_ovf = 1'b1;
        step();
        enc_valid = 1'b0;
        clr_ovf   = 1'b0;
        check("setwins_overflow", 32'(overflow), 1);
        check("setwins_count", 32'(count), 16);
        check("drop_head", 32'(rd_data), 32'h60);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("setwins_clear", 32'(overflow), 0);
        rd_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drop_pop_%0d", i), 32'(rd_data), 32'(8'h60 + i));
            step();
        end
        rd_ready = 1'b0;
        check("drop_drained", 32'(count), 0);

        // pointer wrap: 40 events with continuous reads, scoreboard ordering
        rd_ready  = 1'b1;
        enc_valid = 1'b1;
        for (int i = 0; i < 40; i++) begin
            check($sformatf("wrap_valid_%0d", i), 32'(rd_valid), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                check($sformatf("wrap_data_%0d", i), 32'(rd_data), 32'(exp_q[0]));
                void'(exp_q.pop_front());
            end
            enc_in = 8'(8'h80 + i);
            exp_q.push_back(8'(8'h80 + i));
            step();
            check($sformatf("wrap_occ_%0d", i), 32'(count <= 5'd3), 1);
        end
        enc_valid = 1'b0;
        while (exp_q.size() != 0) begin
            check("wrap_tail_data", 32'(rd_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
            step();
        end
        rd_ready = 1'b0;
        check("wrap_drained", 32'(count), 0);

        // reset mid-stream
        enc_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            enc_in = 8'(8'hA0 + i);
            step();
        end
        check("rst_pre_count", 32'(count), 7);
        enc_in = 8'hA7;
        rst_n  = 1'b0;
        #1;
        check("rst_async_count", 32'(count), 0);
        check("rst_async_valid", 32'(rd_valid), 0);
        check("rst_async_overflow", 32'(overflow), 0);
        step();
        rst_n = 1'b1;
        step();
        check("rst_new_count", 32'(count), 1);
        check("rst_new_data", 32'(rd_data), 32'hA7);
        step();
        check("rst_held_count", 32'(count), 1);
        enc_valid = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/enc_event_fifo.md
ENC_EVENT_FIFO -- requirements
Module: enc_event_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 8, the index width; it matches the 256-to-8 encoder output.
REQ-002 SHALL have parameter DEPTH, default 16, the number of FIFO entries; it must be a power of two and at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port enc_in, input, WIDTH bits: the encoded index from the upstream encoder `out`.
REQ-006 SHALL have port enc_valid, input, 1 bit: the upstream encoder `valid`, a level signal.
REQ-007 SHALL have port rd_data, output, WIDTH bits: the index at the FIFO head.
REQ-008 SHALL have port rd_valid, output, 1 bit: the FIFO is non-empty and rd_data is meaningful.
REQ-009 SHALL have port rd_ready, input, 1 bit: the consumer accepts the head.
REQ-010 SHALL have port count, output, $clog2(DEPTH)+1 bits: the number of stored entries.
REQ-011 SHALL have port full, output, 1 bit: count == DEPTH.
REQ-012 SHALL have port overflow, output, 1 bit: a sticky flag meaning at least one event was dropped.
REQ-013 SHALL have port clr_ovf, input, 1 bit: a synchronous clear for overflow.

Function
REQ-014 SHALL register prev_valid <= enc_valid and prev_idx <= enc_in every cycle.
REQ-015 SHALL define event ev = enc_valid & (~prev_valid | enc_in != prev_idx); a held valid with an unchanged index is one event only.
REQ-016 SHALL define pop = rd_valid & rd_ready and push = ev & (~full | pop).
REQ-017 SHALL, on push, write enc_in to mem[wr_ptr] and increment wr_ptr modulo DEPTH (DEPTH-1 wraps to 0).
REQ-018 SHALL, on pop, increment rd_ptr modulo DEPTH.
REQ-019 SHALL update count as +1 on push only, -1 on pop only, and unchanged on both or neither.
REQ-020 SHALL drive rd_data = mem[rd_ptr] combinationally from registered storage, and rd_valid = (count != 0).
REQ-021 SHALL show the event on rd_valid/rd_data in cycle t+1 when the event is sampled in cycle t (latency 1) if the FIFO was empty.
REQ-022 SHALL operate in occupancy states EMPTY (count 0), PARTIAL, and FULL (count DEPTH), with transitions only by ±1 per cycle.
REQ-023 SHALL, when FULL with simultaneous pop and ev, accept the push, keep count at DEPTH, and leave overflow unchanged.
REQ-024 SHALL, when FULL with ev and no pop, drop the event, leave mem, pointers and count unchanged, and set overflow to 1.
REQ-025 SHALL, when EMPTY with rd_ready high, not pop, leave count at 0, and keep rd_data as don't-care.
REQ-026 SHALL, when clr_ovf and an overflow set condition occur in the same cycle, leave overflow = 1 (set wins).
REQ-027 SHALL treat rd_data as stable while rd_valid=1 and rd_ready=0.
REQ-028 SHALL NOT reset the contents of mem.

Reset
REQ-029 SHALL, while rst_n=0, force wr_ptr, rd_ptr, count, prev_valid, prev_idx and overflow to 0 asynchronously; consequently rd_valid=0 and full=0.
REQ-030 SHALL discard all stored entries and drop any in-flight event on reset asserted mid-operation; the first cycle after release treats enc_valid as a new event.

Structure
REQ-031 SHALL take WIDTH and DEPTH defaults and the count-width function from the shared package enc_pkg, which the encoder stage also uses.
REQ-032 SHALL be flat, with a single sub-module enc_edge_detect (prev registers plus ev generation) instantiated once.

Verification
REQ-033 SHALL cover event collapse: enc_valid=1, enc_in=8'h2A held 5 cycles -> exactly one entry, rd_data=8'h2A one cycle later, count=1.
REQ-034 SHALL cover index change: enc_in 8'h05 then 8'hFF with valid held, rd_ready=0 -> count=2; pops yield 8'h05 then 8'hFF.
REQ-035 SHALL cover fill and overflow: 17 distinct events, rd_ready=0, DEPTH=16 -> full=1, count=16, overflow=1; 16 pops return the first 16 values in order.
REQ-036 SHALL cover full with simultaneous push and pop: count=16, ev and pop in the same cycle -> count stays 16, overflow stays 0, new value delivered last.
REQ-037 SHALL cover pointer wrap: 40 events interleaved with pops, occupancy kept at 3 or less -> output order equals input order across the wrap.
REQ-038 SHALL cover reset mid-stream: count=7, rst_n low 1 cycle -> count=0, rd_valid=0, overflow=0 immediately; enc_valid held high gives one new entry after release.
